// File: rtl/gpr_mp_if.sv
// gpr_mp_if - bus bundle for the multi-port GPR file.
//   Core write ports: wr_we_i / wr_addr_i / wr_data_i (packed, port k at slice k)
//   Core read ports : rd_re_i / rd_addr_i in, rd_data_o out (combinational)
//   Debug channel   : dbg_req_i / dbg_we_i / dbg_addr_i / dbg_wdata_i in,
//                     dbg_gnt_o / dbg_rvalid_o / dbg_rdata_o / dbg_err_o out
// master = the core/debugger side, slave = the register file.
interface gpr_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) ();
    logic [NUM_WR-1:0]        wr_we_i;
    logic [NUM_WR*ADDR_W-1:0] wr_addr_i;
    logic [NUM_WR*DATA_W-1:0] wr_data_i;
    logic [NUM_RD-1:0]        rd_re_i;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic                     dbg_req_i;
    logic                     dbg_we_i;
    logic [ADDR_W-1:0]        dbg_addr_i;
    logic [DATA_W-1:0]        dbg_wdata_i;
    logic                     dbg_gnt_o;
    logic                     dbg_rvalid_o;
    logic [DATA_W-1:0]        dbg_rdata_o;
    logic                     dbg_err_o;

    modport master (
        output wr_we_i, wr_addr_i, wr_data_i, rd_re_i, rd_addr_i,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  rd_data_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o
    );

    modport slave (
        input  wr_we_i, wr_addr_i, wr_data_i, rd_re_i, rd_addr_i,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output rd_data_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o
    );
endinterface

// File: rtl/gpr_mp.sv
// gpr_mp - multi-port general-purpose register file with a debug access port.
//   clk_i    : clock, all state on the rising edge
//   n_rst_i  : asynchronous active-low reset, clears the array and the debug FSM
//   bus      : gpr_mp_if.slave - NUM_WR prioritised write ports (lower index wins),
//              NUM_RD combinational read ports, and a req/gnt/rvalid debug channel
//              that only touches the array on cycles without core writes.
// Optional feature: define GPR_BYPASS_EN to forward same-cycle write data to
// matching read ports; undefined, reads see the array only.
//
// Debug FSM
//   state | meaning
//   IDLE  | gnt high, waiting for dbg_req_i
//   PEND  | access latched, waits for a cycle with no core write (or timeout)
//   RESP  | rvalid pulse, result/err presented
module gpr_mp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 2,
    parameter int ZERO_REG    = 1,
    parameter int DBG_TIMEOUT = 15
) (
    input logic        clk_i,
    input logic        n_rst_i,
    gpr_mp_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    // A zero-width counter is illegal, so DBG_TIMEOUT=0 keeps one unused bit.
    localparam int CNT_W = (DBG_TIMEOUT > 0) ? $clog2(DBG_TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic blocked;
    logic timeout_hit;
    logic lat_zero;
    logic dbg_commit;

    assign blocked     = |bus.wr_we_i;
    assign timeout_hit = (DBG_TIMEOUT != 0) && (stall_cnt == CNT_W'(DBG_TIMEOUT));
    assign lat_zero    = (ZERO_REG != 0) && (lat_addr == '0);
    // Only fires on a cycle with no core write, so the array never sees two writers.
    assign dbg_commit  = (state == ST_PEND) && !blocked && lat_we && !lat_zero;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // Walk from the lowest priority port up so the lowest index lands last.
            for (int k = NUM_WR - 1; k >= 0; k--) begin
                if (bus.wr_we_i[k] &&
                    !((ZERO_REG != 0) && (bus.wr_addr_i[k*ADDR_W +: ADDR_W] == '0)))
                    mem[bus.wr_addr_i[k*ADDR_W +: ADDR_W]] <= bus.wr_data_i[k*DATA_W +: DATA_W];
            end
            if (dbg_commit) mem[lat_addr] <= lat_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state     <= ST_IDLE;
            stall_cnt <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.dbg_req_i) begin
                        lat_we    <= bus.dbg_we_i;
                        lat_addr  <= bus.dbg_addr_i;
                        lat_wdata <= bus.dbg_wdata_i;
                        stall_cnt <= '0;
                        state     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (blocked) begin
                        if (timeout_hit) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (stall_cnt != {CNT_W{1'b1}}) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end else begin
                        if (!lat_we) rdata_q <= lat_zero ? '0 : mem[lat_addr];
                        err_q <= 1'b0;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dbg_gnt_o    = (state == ST_IDLE);
    assign bus.dbg_rvalid_o = (state == ST_RESP);
    assign bus.dbg_rdata_o  = rdata_q;
    assign bus.dbg_err_o    = err_q;

    always_comb begin
        bus.rd_data_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (n_rst_i && bus.rd_re_i[k] &&
                !((ZERO_REG != 0) && (bus.rd_addr_i[k*ADDR_W +: ADDR_W] == '0))) begin
                bus.rd_data_o[k*DATA_W +: DATA_W] = mem[bus.rd_addr_i[k*ADDR_W +: ADDR_W]];
`ifdef GPR_BYPASS_EN
                // Highest-priority matching write port is applied last.
                for (int j = NUM_WR - 1; j >= 0; j--) begin
                    if (bus.wr_we_i[j] &&
                        (bus.wr_addr_i[j*ADDR_W +: ADDR_W] == bus.rd_addr_i[k*ADDR_W +: ADDR_W]))
                        bus.rd_data_o[k*DATA_W +: DATA_W] = bus.wr_data_i[j*DATA_W +: DATA_W];
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_gpr_mp.sv
module tb_gpr_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    gpr_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    gpr_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
        .ZERO_REG(1), .DBG_TIMEOUT(TO)
    ) dut (
        .clk_i  (clk),
        .n_rst_i(n_rst),
        .bus    (bus)
    );

    typedef struct {
        int          acc;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } dbg_exp_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] model [32];
    logic [31:0] last_rdata = '0;
    logic [63:0] rd_q [$];
    dbg_exp_t    dbg_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected read value from the architectural rules, using the reference array.
    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
        if (!re || ra == 5'd0) return 32'd0;
`ifdef GPR_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (bus.wr_we_i[j] && bus.wr_addr_i[j*AW +: AW] == ra) return bus.wr_data_i[j*DW +: DW];
`endif
        return model[ra];
    endfunction

    task automatic cyc_drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                             input logic [31:0] wd0, input logic [31:0] wd1,
                             input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
        bus.wr_we_i   = we;
        bus.wr_addr_i = {wa1, wa0};
        bus.wr_data_i = {wd1, wd0};
        bus.rd_re_i   = re;
        bus.rd_addr_i = {ra1, ra0};
        rd_q.push_back({exp_rd(re[1], ra1), exp_rd(re[0], ra0)});
        @(posedge clk);
        if (we[1] && wa1 != 5'd0) model[wa1] = wd1;
        if (we[0] && wa0 != 5'd0) model[wa0] = wd0;
        #1;
    endtask

    task automatic rand_cycle(input bit allow_wr, input bit force_wr);
        logic [1:0] we;
        logic [4:0] wa0, wa1, ra0, ra1;
        we  = force_wr ? 2'($urandom_range(1, 3)) : (allow_wr ? 2'($urandom) : 2'b00);
        wa0 = 5'($urandom);
        wa1 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom);
        ra0 = ($urandom_range(0, 1) == 0) ? wa0 : 5'($urandom);
        ra1 = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom);
        cyc_drive(we, wa0, wa1, $urandom, $urandom, 2'($urandom), ra0, ra1);
    endtask

    // blk = number of consecutive core-write cycles right after accept.
    task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] wd, input int blk);
        int          acc;
        int          lat;
        logic        err;
        logic [31:0] rd;
        bit          got;
        bus.dbg_req_i   = 1'b1;
        bus.dbg_we_i    = we;
        bus.dbg_addr_i  = addr;
        bus.dbg_wdata_i = wd;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (bus.dbg_gnt_o) got = 1'b1;
            rand_cycle(1'b1, 1'b0);
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL dbg_gnt_wait: gnt never seen within 8 cycles");
            bus.dbg_req_i = 1'b0;
            return;
        end
        acc = cyc;
        bus.dbg_req_i   = 1'b0;
        bus.dbg_we_i    = 1'($urandom);
        bus.dbg_addr_i  = 5'($urandom);
        bus.dbg_wdata_i = $urandom;
        check("gnt_pend", 64'(bus.dbg_gnt_o), 64'd0);
        if (TO != 0 && blk > TO) begin
            for (int i = 0; i <= TO; i++) rand_cycle(1'b1, 1'b1);
            err = 1'b1;
            rd  = last_rdata;
            lat = TO + 2;
        end else begin
            for (int i = 0; i < blk; i++) rand_cycle(1'b1, 1'b1);
            rand_cycle(1'b0, 1'b0);
            err = 1'b0;
            if (we) begin
                if (addr != 5'd0) model[addr] = wd;
                rd = last_rdata;
            end else begin
                rd = model[addr];
            end
            lat = blk + 2;
        end
        last_rdata = rd;
        dbg_q.push_back('{acc, lat, err, rd});
        rand_cycle(1'b1, 1'b0);
        check("gnt_after_resp", 64'(bus.dbg_gnt_o), 64'd1);
        check("dbg_rsp_seen", 64'(dbg_q.size()), 64'd0);
        dbg_q.delete();
    endtask

    // Monitor: compares every presented output against the queued expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        dbg_exp_t    d;
        if (n_rst) begin
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check("core_rd", bus.rd_data_o, e);
            end
            if (bus.dbg_rvalid_o) begin
                if (dbg_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dbg_rvalid: unexpected pulse at cycle %0d", cyc);
                end else begin
                    d = dbg_q.pop_front();
                    check("dbg_lat", 64'(cyc - d.acc + 1), 64'(d.lat));
                    check("dbg_err", 64'(bus.dbg_err_o), 64'(d.err));
                    check("dbg_rdata", 64'(bus.dbg_rdata_o), 64'(d.rdata));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        bus.wr_we_i = '0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        bus.rd_re_i = '1; bus.rd_addr_i = {5'd3, 5'd1};
        bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;
        #12;
        check("rst_gnt", 64'(bus.dbg_gnt_o), 64'd1);
        check("rst_rvalid", 64'(bus.dbg_rvalid_o), 64'd0);
        check("rst_rdata", 64'(bus.dbg_rdata_o), 64'd0);
        check("rst_err", 64'(bus.dbg_err_o), 64'd0);
        check("rst_rd", bus.rd_data_o, 64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        for (int a = 1; a < 32; a++) cyc_drive(2'b00, 5'd0, 5'd0, 0, 0, 2'b11, 5'(a), 5'(32 - a));
        cyc_drive(2'b01, 5'd0, 5'd0, 32'hDEAD_BEEF, 0, 2'b11, 5'd0, 5'd0);
        cyc_drive(2'b00, 5'd0, 5'd0, 0, 0, 2'b11, 5'd0, 5'd0);

        cyc_drive(2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 2'b11, 5'd5, 5'd5);
        cyc_drive(2'b00, 5'd0, 5'd0, 0, 0, 2'b11, 5'd5, 5'd5);
        cyc_drive(2'b10, 5'd0, 5'd6, 0, 32'h66, 2'b01, 5'd6, 5'd6);

        dbg_access(1'b1, 5'd7, 32'hCAFE_F00D, 0);
        cyc_drive(2'b00, 5'd0, 5'd0, 0, 0, 2'b11, 5'd7, 5'd7);
        dbg_access(1'b0, 5'd7, 32'h0, 3);
        dbg_access(1'b1, 5'd9, 32'h1234, 100);
        cyc_drive(2'b00, 5'd0, 5'd0, 0, 0, 2'b11, 5'd9, 5'd7);
        dbg_access(1'b0, 5'd0, 32'h0, 1);

        // Reset while a debug write is pending: no rvalid, everything cleared.
        bus.dbg_req_i = 1'b1; bus.dbg_we_i = 1'b1; bus.dbg_addr_i = 5'd3; bus.dbg_wdata_i = 32'h5A5A;
        check("gnt_before_rst_txn", 64'(bus.dbg_gnt_o), 64'd1);
        cyc_drive(2'b00, 5'd0, 5'd0, 0, 0, 2'b00, 5'd0, 5'd0);
        bus.dbg_req_i = 1'b0;
        check("gnt_pend_rst", 64'(bus.dbg_gnt_o), 64'd0);
        n_rst = 1'b0;
        bus.wr_we_i = 2'b11; bus.wr_addr_i = {5'd7, 5'd7}; bus.rd_re_i = 2'b11; bus.rd_addr_i = {5'd7, 5'd5};
        #1;
        check("rd_in_reset", bus.rd_data_o, 64'd0);
        check("gnt_in_reset", 64'(bus.dbg_gnt_o), 64'd1);
        for (int i = 0; i < 32; i++) model[i] = '0;
        last_rdata = '0;
        rd_q.delete();
        dbg_q.delete();
        bus.wr_we_i = '0;
        @(posedge clk); @(posedge clk); #1;
        n_rst = 1'b1;
        check("gnt_after_rst", 64'(bus.dbg_gnt_o), 64'd1);
        for (int i = 0; i < 4; i++) cyc_drive(2'b00, 5'd0, 5'd0, 0, 0, 2'b11, 5'd7, 5'(5 + i));
        dbg_access(1'b0, 5'd3, 32'h0, 0);

        for (int it = 0; it < 60; it++) begin
            int n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) rand_cycle(1'b1, 1'b0);
            if ($urandom_range(0, 1) == 0)
                dbg_access(1'($urandom), 5'($urandom), $urandom,
                           ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4));
        end
        for (int a = 0; a < 32; a++) cyc_drive(2'b00, 5'd0, 5'd0, 0, 0, 2'b11, 5'(a), 5'(31 - a));

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
